// File: rtl/cond_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : cond_unit_pkg
//  Desc     : Shared types and constants for the execute-stage condition unit:
//             ARM condition-code enum, RISC-V branch funct3 values and the
//             bit positions of N/Z/C/V inside the 4-bit flags word.
//  Revision : 1.0  initial release
// ============================================================================
package cond_unit_pkg;

  // ARM condition field encodings
  typedef enum logic [3:0] {
    COND_EQ = 4'b0000,
    COND_NE = 4'b0001,
    COND_CS = 4'b0010,
    COND_CC = 4'b0011,
    COND_MI = 4'b0100,
    COND_PL = 4'b0101,
    COND_VS = 4'b0110,
    COND_VC = 4'b0111,
    COND_HI = 4'b1000,
    COND_LS = 4'b1001,
    COND_GE = 4'b1010,
    COND_LT = 4'b1011,
    COND_GT = 4'b1100,
    COND_LE = 4'b1101,
    COND_AL = 4'b1110,
    COND_NV = 4'b1111
  } cond_e;

  // RISC-V conditional branch funct3 values
  localparam logic [2:0] C_F3_BEQ  = 3'b000;
  localparam logic [2:0] C_F3_BNE  = 3'b001;
  localparam logic [2:0] C_F3_BLT  = 3'b100;
  localparam logic [2:0] C_F3_BGE  = 3'b101;
  localparam logic [2:0] C_F3_BLTU = 3'b110;
  localparam logic [2:0] C_F3_BGEU = 3'b111;

  // Flag bit positions within {N,Z,C,V}
  localparam int C_FLAG_N = 3;
  localparam int C_FLAG_Z = 2;
  localparam int C_FLAG_C = 1;
  localparam int C_FLAG_V = 0;

endpackage
`default_nettype wire

// File: rtl/cond_unit_check.sv
`default_nettype none
// ============================================================================
//  Module   : cond_check
//  Desc     : Combinational ARM condition-code evaluator. Compares the
//             instruction's condition field against the architectural flags.
//  Revision : 1.0  initial release
// ============================================================================
module cond_check
  import cond_unit_pkg::*;
(
  input  logic [3:0] CondE,
  input  logic [3:0] FlagsQ,
  output logic       CondExE
);

  logic n, z, c, v;

  assign n = FlagsQ[C_FLAG_N];
  assign z = FlagsQ[C_FLAG_Z];
  assign c = FlagsQ[C_FLAG_C];
  assign v = FlagsQ[C_FLAG_V];

  // Decode each condition code into its flag predicate
  always_comb begin
    CondExE = 1'b0;
    case (CondE)
      COND_EQ: CondExE = z;
      COND_NE: CondExE = ~z;
      COND_CS: CondExE = c;
      COND_CC: CondExE = ~c;
      COND_MI: CondExE = n;
      COND_PL: CondExE = ~n;
      COND_VS: CondExE = v;
      COND_VC: CondExE = ~v;
      COND_HI: CondExE = c & ~z;
      COND_LS: CondExE = ~c | z;
      COND_GE: CondExE = (n == v);
      COND_LT: CondExE = (n != v);
      COND_GT: CondExE = ~z & (n == v);
      COND_LE: CondExE = z | (n != v);
      COND_AL: CondExE = 1'b1;
      default: CondExE = 1'b0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/cond_unit.sv
`default_nettype none
// ============================================================================
//  Module   : cond_unit
//  Desc     : Execute-stage condition unit. Holds the NZCV flags register,
//             gates ARM RegWrite/MemWrite/PCSrc on the condition result and
//             resolves RISC-V conditional branches.
//             Optional feature macro: COND_RV_BRANCH_EN (RISC-V branch
//             evaluation; when undefined BranchTakenE is tied low).
//  Revision : 1.0  initial release
// ============================================================================
module cond_unit
  import cond_unit_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       StallE,
  input  logic       FlushE,
  input  logic       IsArmE,
  input  logic [3:0] CondE,
  input  logic [1:0] FlagWriteE,
  input  logic [3:0] ALUFlags,
  input  logic       ZeroE,
  input  logic       BranchE,
  input  logic [2:0] Funct3E,
  input  logic       RegWriteE,
  input  logic       MemWriteE,
  input  logic       PCSrcE,
  output logic       RegWriteGatedE,
  output logic       MemWriteGatedE,
  output logic       PCSrcGatedE,
  output logic       CondExE,
  output logic       BranchTakenE,
  output logic [3:0] FlagsQ
);

  logic [3:0] flags_q;
  logic [3:0] flags_d;
  logic       active;

  // Reset is folded in so outputs drop the moment reset rises, not at an edge
  assign active = ~FlushE & ~reset;
  assign FlagsQ = flags_q;

  // Condition is evaluated against registered flags only (no same-cycle bypass)
  cond_check u_cond_check (
    .CondE   (CondE),
    .FlagsQ  (flags_q),
    .CondExE (CondExE)
  );

  // Next flags: each half written independently, only by a live ARM instruction
  always_comb begin
    flags_d = flags_q;
    if (active && !StallE && IsArmE && CondExE) begin
      if (FlagWriteE[1]) flags_d[C_FLAG_N:C_FLAG_Z] = ALUFlags[C_FLAG_N:C_FLAG_Z];
      if (FlagWriteE[0]) flags_d[C_FLAG_C:C_FLAG_V] = ALUFlags[C_FLAG_C:C_FLAG_V];
    end
  end

  // Architectural flags register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) flags_q <= 4'b0000;
    else       flags_q <= flags_d;
  end

  // Control gating: ARM honours the condition, RISC-V only honours bubbles
  always_comb begin
    if (IsArmE) begin
      RegWriteGatedE = RegWriteE & CondExE & active;
      MemWriteGatedE = MemWriteE & CondExE & active;
      PCSrcGatedE    = PCSrcE    & CondExE & active;
    end else begin
      RegWriteGatedE = RegWriteE & active;
      MemWriteGatedE = MemWriteE & active;
      PCSrcGatedE    = PCSrcE    & active;
    end
  end

`ifdef COND_RV_BRANCH_EN
  logic rv_cond;

  // RISC-V branch predicate from the live compare subtraction
  always_comb begin
    rv_cond = 1'b0;
    case (Funct3E)
      C_F3_BEQ:  rv_cond = ZeroE;
      C_F3_BNE:  rv_cond = ~ZeroE;
      C_F3_BLT:  rv_cond = (ALUFlags[C_FLAG_N] != ALUFlags[C_FLAG_V]);
      C_F3_BGE:  rv_cond = (ALUFlags[C_FLAG_N] == ALUFlags[C_FLAG_V]);
      C_F3_BLTU: rv_cond = ~ALUFlags[C_FLAG_C];
      C_F3_BGEU: rv_cond = ALUFlags[C_FLAG_C];
      default:   rv_cond = 1'b0;
    endcase
  end

  assign BranchTakenE = BranchE & ~IsArmE & active & rv_cond;
`else
  logic unused_rv_inputs;

  assign unused_rv_inputs = ^{BranchE, Funct3E, ZeroE};
  assign BranchTakenE     = 1'b0;
`endif

endmodule
`default_nettype wire
